// File: rtl/cpu_fetch_ctrl.sv
// cpu_fetch_ctrl: instruction fetch sequencer issuing word reads and feeding the instruction FIFO,
// with branch redirect that flushes the FIFO and drops stale in-flight responses.
module cpu_fetch_ctrl #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_1000,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        fifo_full_i,
  output logic        fifo_write_en_o,
  output logic [31:0] fifo_data_o,
  output logic        fifo_flush_o,
  output logic [31:0] fifo_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] fetch_addr, pc_q;
  logic [31:0] hold_q [2];
  logic [1:0] outstanding, discard, hold_count;
  logic hold_rd, hold_wr, redirect, accept, push, pop;
  assign redirect = branch_i && state != BOOT;
  assign accept = mem_req_o && mem_gnt_i;
  // a response arriving in a redirect cycle is stale even when it was not yet marked for discard
  assign push = mem_rvalid_i && discard == 2'd0 && !redirect;
  assign pop = fifo_write_en_o;
  assign mem_addr_o = fetch_addr;
  assign fifo_pc_o = pc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= BOOT;
    else state <= state_n;
  end
  always_comb begin
    state_n = redirect ? FLUSH : RUN;
  end
  always_comb begin
    fifo_flush_o = !rst_i && state != RUN;
    mem_req_o = !rst_i && state == RUN && !branch_i
                && ({1'b0, outstanding} + {1'b0, hold_count}) < 3'(MAX_OUTSTANDING);
    fifo_write_en_o = !rst_i && state == RUN && !branch_i && hold_count != 2'd0 && !fifo_full_i;
    fifo_data_o = fifo_write_en_o ? hold_q[hold_rd] : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_addr <= BOOT_ADDRESS;
      pc_q <= BOOT_ADDRESS;
      outstanding <= '0;
      discard <= '0;
      hold_count <= '0;
      hold_rd <= 1'b0;
      hold_wr <= 1'b0;
    end else begin
      outstanding <= outstanding + 2'(accept) - 2'(mem_rvalid_i);
      if (redirect) begin
        fetch_addr <= {branch_target_i[31:2], 2'b00};
        pc_q <= {branch_target_i[31:2], 2'b00};
        discard <= outstanding + 2'(accept) - 2'(mem_rvalid_i);
        hold_count <= '0;
        hold_rd <= 1'b0;
        hold_wr <= 1'b0;
      end else begin
        if (accept) fetch_addr <= fetch_addr + 32'd4;
        if (mem_rvalid_i && discard != 2'd0) discard <= discard - 2'd1;
        if (push) hold_wr <= ~hold_wr;
        if (pop) hold_rd <= ~hold_rd;
        hold_count <= hold_count + 2'(push) - 2'(pop);
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) hold_q[hold_wr] <= mem_rdata_i;
  end
endmodule
